// File: rtl/rdma_sq_fetch_scheduler.sv
// Round-robin WQE-fetch scheduler: shares one DMA read channel between N_QP
// send queues. Tracks per-QP base/producer/consumer state, issues one 64-byte
// WQE read at a time and advances the consumer index on a clean completion.
module rdma_sq_fetch_scheduler #(
    parameter int N_QP          = 8,
    parameter int QP_IDX_BITS   = 3,
    parameter int SQ_DEPTH_BITS = 8,
    parameter int WQE_BYTES     = 64
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     cfg_valid,
    input  logic [QP_IDX_BITS-1:0]   cfg_qp_idx,
    input  logic [63:0]              cfg_base_addr,
    input  logic                     db_valid,
    input  logic [QP_IDX_BITS-1:0]   db_qp_idx,
    input  logic [31:0]              db_prod_idx,
    output logic                     dma_req_valid,
    input  logic                     dma_req_ready,
    output logic [115:0]             dma_req_data,
    output logic [QP_IDX_BITS-1:0]   dma_req_qp,
    input  logic                     dma_done_valid,
    input  logic                     dma_done_err,
    output logic                     cons_valid,
    output logic [QP_IDX_BITS-1:0]   cons_qp,
    output logic [SQ_DEPTH_BITS-1:0] cons_idx,
    output logic [N_QP-1:0]          qp_err,
    output logic                     busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam int                       WQE_SHIFT  = $clog2(WQE_BYTES);
    localparam logic [3:0]               ACCESDESC  = 4'h1;
    localparam logic [SQ_DEPTH_BITS-1:0] IDX_ONE    = SQ_DEPTH_BITS'(1);

    // Per-QP state
    logic [63:0]              base_q [N_QP];
    logic [SQ_DEPTH_BITS-1:0] prod_q [N_QP];
    logic [SQ_DEPTH_BITS-1:0] cons_q [N_QP];
    logic [N_QP-1:0]          cfgd_q;
    logic [N_QP-1:0]          err_q;

    // Scheduler state
    logic [1:0]               state_q, state_d;
    logic [QP_IDX_BITS-1:0]   rr_ptr_q;
    logic [QP_IDX_BITS-1:0]   grant_q;
    logic [115:0]             req_data_q;
    logic                     stale_q;
    logic [N_QP-1:0]          pend_dly_q;
    logic                     cons_valid_q;
    logic [QP_IDX_BITS-1:0]   cons_qp_q;
    logic [SQ_DEPTH_BITS-1:0] cons_idx_q;

    // Combinational helpers
    logic [N_QP-1:0]          pend_now;
    logic [N_QP-1:0]          eligible;
    logic                     grant_found;
    logic [QP_IDX_BITS-1:0]   grant_idx;
    logic [QP_IDX_BITS-1:0]   cand;
    logic [63:0]              fetch_paddr;
    logic                     cfg_hits_grant;
    logic                     stale_now;
    logic                     done_fire;
    logic                     done_ok;
    logic                     done_bad;

    // Only the low SQ_DEPTH_BITS of the doorbell value carry an index.
    logic unused_db_hi;
    assign unused_db_hi = ^db_prod_idx[31:SQ_DEPTH_BITS];

    // Pending per QP; the delayed copy gives the doorbell one extra cycle
    // before arbitration, and ANDing with the live view keeps a just-updated
    // consumer index from being refetched on the IDLE cycle after completion.
    always_comb begin
        for (int q = 0; q < N_QP; q++) begin
            pend_now[q] = cfgd_q[q] & ~err_q[q] & (prod_q[q] != cons_q[q]);
        end
        eligible = pend_now & pend_dly_q;
    end

    // Round-robin search starting one past the last grant, with wrap.
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= N_QP; i++) begin
            cand = QP_IDX_BITS'((int'(rr_ptr_q) + i) % N_QP);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Request address and completion qualification.
    always_comb begin
        fetch_paddr    = base_q[grant_idx] + (64'(cons_q[grant_idx]) << WQE_SHIFT);
        cfg_hits_grant = cfg_valid && (cfg_qp_idx == grant_q);
        // A cfg landing in the same cycle as the completion also makes it stale.
        stale_now      = stale_q | cfg_hits_grant;
        done_fire      = (state_q == ST_WAIT) && dma_done_valid;
        done_ok        = done_fire && !stale_now && !dma_done_err;
        done_bad       = done_fire && !stale_now &&  dma_done_err;
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_found)    state_d = ST_REQ;
            ST_REQ:  if (dma_req_ready)  state_d = ST_WAIT;
            ST_WAIT: if (dma_done_valid) state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // Per-QP register file: cfg has priority over doorbell and completion.
    // NOTE: these arrays are small flops, not RAM, so they take the async reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int q = 0; q < N_QP; q++) begin
                base_q[q] <= '0;
                prod_q[q] <= '0;
                cons_q[q] <= '0;
            end
            cfgd_q <= '0;
            err_q  <= '0;
        end else begin
            for (int q = 0; q < N_QP; q++) begin
                if (cfg_valid && (cfg_qp_idx == QP_IDX_BITS'(q))) begin
                    base_q[q] <= cfg_base_addr;
                    prod_q[q] <= '0;
                    cons_q[q] <= '0;
                    cfgd_q[q] <= 1'b1;
                    err_q[q]  <= 1'b0;
                end else begin
                    if (db_valid && (db_qp_idx == QP_IDX_BITS'(q)) && cfgd_q[q]) begin
                        prod_q[q] <= db_prod_idx[SQ_DEPTH_BITS-1:0];
                    end
                    if (done_ok && (grant_q == QP_IDX_BITS'(q))) begin
                        cons_q[q] <= cons_q[q] + IDX_ONE;
                    end
                    if (done_bad && (grant_q == QP_IDX_BITS'(q))) begin
                        err_q[q] <= 1'b1;
                    end
                end
            end
        end
    end

    // Scheduler sequencing: grant capture, stale tracking, consumer pulse.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values of the others.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= QP_IDX_BITS'(N_QP - 1);
            grant_q      <= '0;
            req_data_q   <= '0;
            stale_q      <= 1'b0;
            pend_dly_q   <= '0;
            cons_valid_q <= 1'b0;
            cons_qp_q    <= '0;
            cons_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            pend_dly_q   <= pend_now;
            cons_valid_q <= done_ok;
            if (done_ok) begin
                cons_qp_q  <= grant_q;
                cons_idx_q <= cons_q[grant_q] + IDX_ONE;
            end
            case (state_q)
                ST_IDLE: begin
                    if (grant_found) begin
                        grant_q    <= grant_idx;
                        rr_ptr_q   <= grant_idx;
                        req_data_q <= {ACCESDESC, 48'(WQE_BYTES), fetch_paddr};
                        stale_q    <= 1'b0;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (cfg_hits_grant) stale_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dma_req_valid = (state_q == ST_REQ);
    assign dma_req_data  = req_data_q;
    assign dma_req_qp    = grant_q;
    assign cons_valid    = cons_valid_q;
    assign cons_qp       = cons_qp_q;
    assign cons_idx      = cons_idx_q;
    assign qp_err        = err_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rdma_sq_fetch_scheduler.sv
// Self-checking bench for rdma_sq_fetch_scheduler: a negedge responder plays
// the DMA engine and checks each request and consumer pulse against queues
// of expected results filled by the scenario tasks.
module tb_rdma_sq_fetch_scheduler;

    typedef struct {
        logic [2:0]  qp;
        logic [63:0] paddr;
    } req_exp_t;

    typedef struct {
        logic [2:0] qp;
        logic [7:0] idx;
    } cons_exp_t;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [2:0]   cfg_qp_idx = '0;
    logic [63:0]  cfg_base_addr = '0;
    logic         db_valid = 1'b0;
    logic [2:0]   db_qp_idx = '0;
    logic [31:0]  db_prod_idx = '0;
    logic         dma_req_valid;
    logic         dma_req_ready = 1'b1;
    logic [115:0] dma_req_data;
    logic [2:0]   dma_req_qp;
    logic         dma_done_valid = 1'b0;
    logic         dma_done_err = 1'b0;
    logic         cons_valid;
    logic [2:0]   cons_qp;
    logic [7:0]   cons_idx;
    logic [7:0]   qp_err;
    logic         busy;

    int total = 0;
    int bad = 0;
    int hs_cnt = 0;

    req_exp_t  req_q[$];
    cons_exp_t cons_q[$];

    // Reference model of per-QP state kept by the bench.
    logic [63:0] m_base [8];
    logic [7:0]  m_cons [8];

    // Responder controls
    int         done_timer = 0;
    logic       done_hold = 1'b0;
    logic       done_err_pend = 1'b0;
    logic       err_en = 1'b0;
    logic [2:0] err_qp = '0;

    rdma_sq_fetch_scheduler dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_valid(cfg_valid), .cfg_qp_idx(cfg_qp_idx), .cfg_base_addr(cfg_base_addr),
        .db_valid(db_valid), .db_qp_idx(db_qp_idx), .db_prod_idx(db_prod_idx),
        .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
        .dma_req_data(dma_req_data), .dma_req_qp(dma_req_qp),
        .dma_done_valid(dma_done_valid), .dma_done_err(dma_done_err),
        .cons_valid(cons_valid), .cons_qp(cons_qp), .cons_idx(cons_idx),
        .qp_err(qp_err), .busy(busy)
    );

    always #5 aclk = ~aclk;

    // DMA responder and output scoreboard, sampled on the falling edge.
    always @(negedge aclk) begin
        req_exp_t  er;
        cons_exp_t ec;
        if (!aresetn) begin
            done_timer     = 0;
            dma_done_valid = 1'b0;
            dma_done_err   = 1'b0;
        end else begin
            dma_done_valid = 1'b0;
            dma_done_err   = 1'b0;
            if (done_timer > 0 && !done_hold) begin
                done_timer = done_timer - 1;
                if (done_timer == 0) begin
                    dma_done_valid = 1'b1;
                    dma_done_err   = done_err_pend;
                end
            end
            if (dma_req_valid && dma_req_ready) begin
                hs_cnt++;
                total++;
                if (req_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_req qp=%0d data=%h", dma_req_qp, dma_req_data);
                end else begin
                    er = req_q.pop_front();
                    if (dma_req_qp !== er.qp ||
                        dma_req_data !== {4'h1, 48'd64, er.paddr}) begin
                        bad++;
                        $display("FAIL req got qp=%0d data=%h exp qp=%0d paddr=%h",
                                 dma_req_qp, dma_req_data, er.qp, er.paddr);
                    end
                end
                done_timer    = 2;
                done_err_pend = err_en && (dma_req_qp == err_qp);
            end
            if (cons_valid) begin
                total++;
                if (cons_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_cons qp=%0d idx=%0d", cons_qp, cons_idx);
                end else begin
                    ec = cons_q.pop_front();
                    if (cons_qp !== ec.qp || cons_idx !== ec.idx) begin
                        bad++;
                        $display("FAIL cons got qp=%0d idx=%0d exp qp=%0d idx=%0d",
                                 cons_qp, cons_idx, ec.qp, ec.idx);
                    end
                end
            end
        end
    end

    task automatic do_cfg(input logic [2:0] q, input logic [63:0] addr);
        @(negedge aclk);
        cfg_valid = 1'b1; cfg_qp_idx = q; cfg_base_addr = addr;
        @(negedge aclk);
        cfg_valid = 1'b0;
        m_base[q] = addr;
        m_cons[q] = 8'd0;
    endtask

    task automatic do_db(input logic [2:0] q, input logic [31:0] prod);
        @(negedge aclk);
        db_valid = 1'b1; db_qp_idx = q; db_prod_idx = prod;
        @(negedge aclk);
        db_valid = 1'b0;
    endtask

    // Push n successful fetches for one QP from the model's consumer index.
    task automatic expect_fetches(input logic [2:0] q, input int n);
        for (int k = 0; k < n; k++) begin
            req_q.push_back('{qp: q, paddr: m_base[q] + {48'd0, m_cons[q], 6'd0}});
            m_cons[q] = m_cons[q] + 8'd1;
            cons_q.push_back('{qp: q, idx: m_cons[q]});
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!(req_q.size() == 0 && cons_q.size() == 0 && !busy) && n < budget) begin
            @(negedge aclk);
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s_timeout left_req=%0d left_cons=%0d busy=%0b",
                     name, req_q.size(), cons_q.size(), busy);
        end
    endtask

    task automatic check_quiet(input string name);
        repeat (4) @(negedge aclk);
        total++;
        if (busy !== 1'b0 || dma_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_quiet busy=%0b valid=%0b exp 0 0", name, busy, dma_req_valid);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        total++;
        if (dma_req_valid !== 1'b0 || dma_req_data !== '0 || dma_req_qp !== '0 ||
            cons_valid !== 1'b0 || cons_qp !== '0 || cons_idx !== '0 ||
            qp_err !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_outputs valid=%0b data=%h qp=%0d cv=%0b cq=%0d ci=%0d err=%h busy=%0b exp all 0",
                     name, dma_req_valid, dma_req_data, dma_req_qp, cons_valid,
                     cons_qp, cons_idx, qp_err, busy);
        end
    endtask

    task automatic test_reset();
        for (int q = 0; q < 8; q++) begin m_base[q] = '0; m_cons[q] = '0; end
        repeat (3) @(negedge aclk);
        check_outputs_zero("reset_asserted");
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        check_outputs_zero("reset_released");
    endtask

    // T1: single QP, three fetches, plus doorbell-to-request latency.
    task automatic test_single_qp();
        do_cfg(3'd0, 64'h1000);
        expect_fetches(3'd0, 3);
        db_valid = 1'b1; db_qp_idx = 3'd0; db_prod_idx = 32'd3;
        @(posedge aclk);            // edge t samples the doorbell
        #1 db_valid = 1'b0;
        @(posedge aclk); #1;        // after t+1
        total++;
        if (dma_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_t1 valid=%0b exp 0", dma_req_valid);
        end
        @(posedge aclk); #1;        // after t+2
        total++;
        if (dma_req_valid !== 1'b1) begin
            bad++;
            $display("FAIL latency_t2 valid=%0b exp 1", dma_req_valid);
        end
        wait_idle("single_qp", 200);
        check_quiet("single_qp");
    endtask

    // T2: three QPs doorbelled in one window are served 1,2,5,1,2,5.
    task automatic test_round_robin();
        logic [2:0] qs [3];
        qs[0] = 3'd1; qs[1] = 3'd2; qs[2] = 3'd5;
        do_cfg(3'd1, 64'h10_0000);
        do_cfg(3'd2, 64'h20_0000);
        do_cfg(3'd5, 64'h50_0000);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 3; k++) expect_fetches(qs[k], 1);
        @(negedge aclk);
        db_valid = 1'b1; db_prod_idx = 32'd2;
        db_qp_idx = 3'd1; @(negedge aclk);
        db_qp_idx = 3'd2; @(negedge aclk);
        db_qp_idx = 3'd5; @(negedge aclk);
        db_valid = 1'b0;
        wait_idle("round_robin", 300);
    endtask

    // T3: QP0 consumer index walks to 255, then wraps through 0.
    task automatic test_wrap();
        expect_fetches(3'd0, 255 - int'(m_cons[0]));
        do_db(3'd0, 32'd255);
        wait_idle("wrap_fill", 5000);
        expect_fetches(3'd0, 2);   // base+255*64 -> idx 0, then base+0 -> idx 1
        do_db(3'd0, 32'hFFFF_FF01); // upper bits ignored, low byte = 1
        wait_idle("wrap_cross", 200);
    endtask

    // T4: backpressure holds request stable with a single handshake.
    task automatic test_backpressure();
        int hs0;
        int n = 0;
        logic [63:0] exp_paddr;
        do_cfg(3'd4, 64'h8000);
        exp_paddr = m_base[4];
        expect_fetches(3'd4, 1);
        dma_req_ready = 1'b0;
        hs0 = hs_cnt;
        do_db(3'd4, 32'd1);
        while (!dma_req_valid && n < 20) begin @(negedge aclk); n++; end
        for (int c = 0; c < 10; c++) begin
            total++;
            if (dma_req_valid !== 1'b1 || dma_req_qp !== 3'd4 ||
                dma_req_data !== {4'h1, 48'd64, exp_paddr}) begin
                bad++;
                $display("FAIL stall_cycle%0d valid=%0b qp=%0d data=%h exp 1 4 %h",
                         c, dma_req_valid, dma_req_qp, dma_req_data,
                         {4'h1, 48'd64, exp_paddr});
            end
            @(negedge aclk);
        end
        dma_req_ready = 1'b1;
        wait_idle("backpressure", 100);
        total++;
        if (hs_cnt !== hs0 + 1) begin
            bad++;
            $display("FAIL stall_handshakes got=%0d exp=%0d", hs_cnt - hs0, 1);
        end
    endtask

    // T5: errored completion halts QP3; cfg clears the halt.
    task automatic test_error();
        int n = 0;
        err_en = 1'b1; err_qp = 3'd3;
        do_cfg(3'd3, 64'hA000);
        req_q.push_back('{qp: 3'd3, paddr: 64'hA000});
        do_db(3'd3, 32'd2);
        while (qp_err[3] !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        wait_idle("error_fetch", 50);
        total++;
        if (qp_err !== 8'h08) begin
            bad++;
            $display("FAIL err_flag got=%h exp=%h", qp_err, 8'h08);
        end
        do_cfg(3'd6, 64'hC000);
        expect_fetches(3'd6, 1);
        do_db(3'd6, 32'd1);
        wait_idle("error_skip", 100);
        check_quiet("error_skip");
        err_en = 1'b0;
        do_cfg(3'd3, 64'hA000);
        total++;
        if (qp_err !== 8'h00) begin
            bad++;
            $display("FAIL err_clear got=%h exp=%h", qp_err, 8'h00);
        end
        expect_fetches(3'd3, 1);
        do_db(3'd3, 32'd1);
        wait_idle("error_recover", 100);
    endtask

    // T6: reset during WAIT forgets the fetch; fresh state afterwards.
    task automatic test_reset_mid_wait();
        int hs0;
        int n = 0;
        do_cfg(3'd0, 64'h2000);
        req_q.push_back('{qp: 3'd0, paddr: 64'h2000});
        done_hold = 1'b1;
        hs0 = hs_cnt;
        do_db(3'd0, 32'd1);
        while (hs_cnt == hs0 && n < 50) begin @(negedge aclk); n++; end
        repeat (2) @(negedge aclk);
        total++;
        if (busy !== 1'b1 || hs_cnt !== hs0 + 1) begin
            bad++;
            $display("FAIL wait_entry busy=%0b hs=%0d exp 1 %0d", busy, hs_cnt, hs0 + 1);
        end
        aresetn = 1'b0;
        #1;
        check_outputs_zero("mid_wait_reset");
        req_q.delete();
        cons_q.delete();
        done_hold = 1'b0;
        for (int q = 0; q < 8; q++) begin m_base[q] = '0; m_cons[q] = '0; end
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        do_db(3'd1, 32'd5);        // unconfigured QP: must be ignored
        check_quiet("unconfigured_db");
        do_cfg(3'd0, 64'h2000);
        expect_fetches(3'd0, 1);
        do_db(3'd0, 32'd1);
        wait_idle("post_reset", 100);
    endtask

    initial begin
        test_reset();
        test_single_qp();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_error();
        test_reset_mid_wait();
        repeat (5) @(negedge aclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
